// File: rtl/game_pkg.sv
// Shared encodings for the game play controller: FSM state codes and level width.
package game_pkg;
  localparam int LEVEL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_PAUSE     = 3'd2,
    ST_LEVEL_GAP = 3'd3,
    ST_OVER      = 3'd4
  } state_e;
endpackage

// File: rtl/game_sequencer_gap_timer.sv
// gap_timer: counts frame strobes while enabled; tc_o fires on the strobe that
// completes GAP_FRAMES. Holds its count while disabled, clears on clr_i or terminal.
module gap_timer #(
  parameter int GAP_FRAMES = 120
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic stb_i,
  output logic tc_o
);
  localparam int CW = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && stb_i && (cnt_q == CW'(GAP_FRAMES - 1));

  // Next count: clear wins, otherwise advance on an enabled strobe, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o)    cnt_d = '0;
    else if (en_i && stb_i) cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: play controller FSM, level speed, saturating score and the
// inter-level gap. Optional HISCORE_EN macro adds a best-score output kept across games.
module game_sequencer
  import game_pkg::*;
#(
  parameter int START_LEVEL = 1,
  parameter int MAX_LEVEL   = 9,
  parameter int GAP_FRAMES  = 120,
  parameter int SCORE_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_start,
  input  logic               i_pause_btn,
  input  logic               i_collide,
  input  logic               i_score_pls,
  input  logic [31:0]        i_lev,
  output logic               o_animate,
  output logic               o_pause,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_done,
  output logic               o_lose,
  output logic [SCORE_W-1:0] o_score,
`ifdef HISCORE_EN
  output logic [SCORE_W-1:0] o_hiscore,
`endif
  output logic [2:0]         o_state
);
  state_e               state_q, state_d;
  logic                 resume_gap_q, resume_gap_d; // pause returns to LEVEL_GAP when set
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [31:0]          lev_q, lev_d;
  logic                 gap_clr, gap_en, gap_tc;

  gap_timer #(.GAP_FRAMES(GAP_FRAMES)) u_gap (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clr_i (gap_clr),
    .en_i  (gap_en),
    .stb_i (i_ani_stb),
    .tc_o  (gap_tc)
  );

  // Next-state, level, score and gap-timer control.
  always_comb begin
    state_d      = state_q;
    resume_gap_d = resume_gap_q;
    level_d      = level_q;
    score_d      = score_q;
    lev_d        = lev_q;
    gap_clr      = 1'b0;
    gap_en       = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (i_start) begin
          state_d = ST_PLAY;
          score_d = '0;
          level_d = LEVEL_W'(START_LEVEL);
          gap_clr = 1'b1;
        end
      end
      ST_PLAY: begin
        if (i_collide) state_d = ST_OVER;
        else if (i_pause_btn) begin
          state_d      = ST_PAUSE;
          resume_gap_d = 1'b0;
        end else if (i_lev != lev_q) begin
          state_d = ST_LEVEL_GAP;
          lev_d   = i_lev;
        end
      end
      ST_PAUSE: begin
        if (i_pause_btn) state_d = resume_gap_q ? ST_LEVEL_GAP : ST_PLAY;
      end
      ST_LEVEL_GAP: begin
        if (i_collide) begin
          state_d = ST_OVER;
          gap_clr = 1'b1;
        end else if (i_pause_btn) begin
          state_d      = ST_PAUSE;
          resume_gap_d = 1'b1;
        end else begin
          gap_en = 1'b1;
          if (gap_tc) begin
            state_d = ST_PLAY;
            level_d = (level_q >= LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                       : level_q + LEVEL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Scoring is live only while the field moves; a pulse alongside a collision counts.
    if ((state_q == ST_PLAY || state_q == ST_LEVEL_GAP) && i_score_pls && (score_q != '1))
      score_d = score_q + SCORE_W'(1);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      resume_gap_q <= 1'b0;
      level_q      <= LEVEL_W'(START_LEVEL);
      score_q      <= '0;
      lev_q        <= i_lev;
    end else begin
      state_q      <= state_d;
      resume_gap_q <= resume_gap_d;
      level_q      <= level_d;
      score_q      <= score_d;
      lev_q        <= lev_d;
    end
  end

`ifdef HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  // Capture the best score as the game ends, including any final coincident pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) hiscore_q <= '0;
    else if (state_q != ST_OVER && state_d == ST_OVER && score_d > hiscore_q)
      hiscore_q <= score_d;
  end

  assign o_hiscore = hiscore_q;
`endif

  assign o_animate = (state_q == ST_PLAY) || (state_q == ST_LEVEL_GAP);
  assign o_pause   = (state_q == ST_PAUSE);
  assign o_done    = (state_q == ST_LEVEL_GAP);
  assign o_lose    = (state_q == ST_OVER);
  assign o_level   = level_q;
  assign o_score   = score_q;
  assign o_state   = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a per-cycle behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_game_sequencer;
  localparam int SMAX = 65535;
  localparam int GAPN = 120;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_ani_stb = 1'b0, i_start = 1'b0, i_pause_btn = 1'b0;
  logic        i_collide = 1'b0, i_score_pls = 1'b0;
  logic [31:0] i_lev = 32'd1;
  logic        o_animate, o_pause, o_done, o_lose;
  logic [3:0]  o_level;
  logic [15:0] o_score;
  logic [2:0]  o_state;
`ifdef HISCORE_EN
  logic [15:0] o_hiscore;
`endif

  int errs = 0;
  int checks = 0;

  // Model state: m_st uses the display codes 0..4, m_ret is where a pause returns to.
  int m_st, m_ret, m_lvl, m_sc, m_gap, m_hi, m_nst;
  logic [31:0] m_lev;

  game_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ani_stb(i_ani_stb), .i_start(i_start),
    .i_pause_btn(i_pause_btn), .i_collide(i_collide), .i_score_pls(i_score_pls),
    .i_lev(i_lev), .o_animate(o_animate), .o_pause(o_pause), .o_level(o_level),
    .o_done(o_done), .o_lose(o_lose), .o_score(o_score),
`ifdef HISCORE_EN
    .o_hiscore(o_hiscore),
`endif
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural rules applied to the inputs present at a clock edge.
  task automatic model_step();
    if (i_rst) begin
      m_st = 0; m_ret = 1; m_lvl = 1; m_sc = 0; m_gap = 0; m_hi = 0; m_lev = i_lev;
      return;
    end
    m_nst = m_st;
    if ((m_st == 1 || m_st == 3) && i_score_pls && m_sc < SMAX) m_sc = m_sc + 1;
    if (m_st == 0 || m_st == 4) begin
      if (i_start) begin m_nst = 1; m_sc = 0; m_lvl = 1; m_gap = 0; end
    end else if (m_st == 1) begin
      if (i_collide) m_nst = 4;
      else if (i_pause_btn) begin m_nst = 2; m_ret = 1; end
      else if (i_lev != m_lev) begin m_nst = 3; m_lev = i_lev; end
    end else if (m_st == 2) begin
      if (i_pause_btn) m_nst = m_ret;
    end else begin
      if (i_collide) begin m_nst = 4; m_gap = 0; end
      else if (i_pause_btn) begin m_nst = 2; m_ret = 3; end
      else if (i_ani_stb) begin
        m_gap = m_gap + 1;
        if (m_gap == GAPN) begin
          m_gap = 0; m_nst = 1;
          m_lvl = (m_lvl + 1 > 9) ? 9 : m_lvl + 1;
        end
      end
    end
    if (m_nst == 4 && m_st != 4 && m_sc > m_hi) m_hi = m_sc;
    m_st = m_nst;
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic model_check();
    logic [31:0] exp_v, act_v;
    exp_v = {m_st[2:0], (m_st == 1 || m_st == 3), (m_st == 2), (m_st == 3), (m_st == 4),
             m_lvl[3:0], m_sc[15:0]};
    act_v = {o_state, o_animate, o_pause, o_done, o_lose, o_level, o_score};
    chk("model_outputs", act_v, exp_v);
`ifdef HISCORE_EN
    chk("model_hiscore", {16'd0, o_hiscore}, m_hi);
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, check at the falling edge.
  task automatic tick(input logic rst, input logic st, input logic pb, input logic col,
                      input logic pls, input logic stb);
    i_rst = rst; i_start = st; i_pause_btn = pb; i_collide = col;
    i_score_pls = pls; i_ani_stb = stb;
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    i_rst = 1'b0; i_start = 1'b0; i_pause_btn = 1'b0; i_collide = 1'b0;
    i_score_pls = 1'b0; i_ani_stb = 1'b0;
    model_check();
  endtask

  task automatic strobes(input int n);
    repeat (n) tick(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    @(negedge i_clk);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_state", o_state, 0);
    chk("rst_level", o_level, 1);
    chk("rst_score", o_score, 0);
    chk("rst_animate", o_animate, 0);
    tick(0, 0, 1, 0, 0, 0);                 // pause in IDLE ignored
    chk("idle_pause_ign", o_state, 0);

    tick(0, 1, 0, 0, 0, 0);
    chk("start_state", o_state, 1);
    chk("start_animate", o_animate, 1);
    chk("start_level", o_level, 1);
    chk("start_score", o_score, 0);
    tick(0, 1, 0, 0, 0, 0);                 // start in PLAY ignored
    chk("play_start_ign", o_state, 1);

    repeat (3) tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("over_score", o_score, 3);
    chk("over_state", o_state, 4);
    chk("over_lose", o_lose, 1);
    chk("over_animate", o_animate, 0);

    tick(0, 1, 0, 0, 0, 0);                 // game 2 scores 5
    chk("restart_score", o_score, 0);
    repeat (5) tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("g2_score", o_score, 5);
    tick(0, 1, 0, 0, 0, 0);                 // game 3 scores 2, last pulse with collision
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 1, 0);
    chk("coincident_score", o_score, 2);
    chk("coincident_state", o_state, 4);
`ifdef HISCORE_EN
    chk("hiscore_kept", o_hiscore, 5);
`endif

    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    chk("pause_state", o_state, 2);
    chk("pause_flag", o_pause, 1);
    tick(0, 0, 0, 1, 0, 0);                 // collision ignored while paused
    chk("pause_collide_ign", o_state, 2);
    tick(0, 0, 1, 0, 0, 0);
    chk("unpause_state", o_state, 1);

    i_lev = 32'd2;
    tick(0, 0, 0, 0, 0, 0);
    chk("gap_state", o_state, 3);
    chk("gap_done", o_done, 1);
    strobes(GAPN - 1);
    chk("gap_119", o_state, 3);
    strobes(1);
    chk("gap_exit_state", o_state, 1);
    chk("gap_exit_level", o_level, 2);

    i_lev = 32'd3;
    tick(0, 0, 0, 0, 0, 0);
    strobes(50);
    tick(0, 0, 1, 0, 0, 0);
    strobes(10);
    chk("gap_paused", o_state, 2);
    tick(0, 0, 1, 0, 0, 0);
    chk("gap_resumed", o_state, 3);
    strobes(69);
    chk("gap_resume_119", o_state, 3);
    strobes(1);
    chk("gap_resume_exit", o_state, 1);
    chk("gap_resume_level", o_level, 3);

    for (int l = 4; l <= 9; l++) begin
      i_lev = l;
      tick(0, 0, 0, 0, 0, 0);
      strobes(GAPN);
    end
    chk("level_9", o_level, 9);
    i_lev = 32'd10;
    tick(0, 0, 0, 0, 0, 0);
    chk("max_gap_done", o_done, 1);
    strobes(GAPN);
    chk("max_gap_state", o_state, 1);
    chk("max_gap_level", o_level, 9);

    repeat (SMAX) tick(0, 0, 0, 0, 1, 0);
    chk("score_ffff", o_score, 16'hFFFF);
    tick(0, 0, 0, 0, 1, 0);
    chk("score_sat", o_score, 16'hFFFF);

    i_lev = 32'd7;
    tick(1, 0, 0, 0, 0, 0);                 // reset mid-PLAY
    chk("midrst_state", o_state, 0);
    chk("midrst_level", o_level, 1);
    chk("midrst_score", o_score, 0);
    chk("midrst_flags", {o_animate, o_pause, o_done, o_lose}, 0);
`ifdef HISCORE_EN
    chk("midrst_hiscore", o_hiscore, 0);
`endif
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("midrst_lev_latched", o_state, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
